spi_frame_rx: RTL and testbench



---
 rtl/spi_frame_pkg.sv | 20 ++
 rtl/spi_edge_detect.sv | 25 ++
 rtl/spi_frame_rx.sv | 144 ++++++++++++++
 tb/tb_spi_frame_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared frame layout and FSM state encoding for the SPI frame receiver.
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_edge_detect.sv
// One-flop edge detector: rise/fall pulses against the previous sample.
module spi_edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    always_comb prev_d = d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= RST_VAL;
        else     prev_q <= prev_d;
    end

    assign rise = d & ~prev_q;
    assign fall = ~d & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: assembles 16-bit R/W + addr + data frames
// and strobes frame_valid for exact-length frames, frame_err otherwise.
module spi_frame_rx
    import spi_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_s,
    input  logic              copi_s,
    input  logic              cs_n_s,
    output logic              frame_valid,
    output logic              frame_rw,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        frame_count
);

    logic sclk_rise;
    logic sclk_fall_unused;
    logic cs_rise;
    logic cs_fall;

    spi_edge_detect #(.RST_VAL(1'b0)) u_sclk_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall_unused)
    );

    // cs_prev resets low, so a frame in flight at reset release is skipped.
    spi_edge_detect #(.RST_VAL(1'b0)) u_cs_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  ovr_q, ovr_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  rw_q, rw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [7:0]            count_q, count_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        ovr_d     = ovr_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        count_d   = count_q;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    ovr_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise && !cs_n_s) begin
                    shreg_d   = {shreg_q[FRAME_BITS-2:0], copi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = FULL;
                end
            end
            FULL: begin
                if (cs_rise) begin
                    if (ovr_q) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        rw_d    = shreg_q[RW_BIT];
                        addr_d  = shreg_q[ADDR_MSB:ADDR_LSB];
                        data_d  = shreg_q[DATA_MSB:0];
                        count_d = count_q + 8'd1;
                    end
                    ovr_d   = 1'b0;
                    state_d = IDLE;
                end else if (sclk_rise && !cs_n_s) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            ovr_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            ovr_q     <= ovr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
        end
    end

    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign frame_rw    = rw_q;
    assign frame_addr  = addr_q;
    assign frame_data  = data_q;
    assign frame_count = count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx with a frame-level reference model.
module tb_spi_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk_s = 1'b0;
    logic       copi_s = 1'b0;
    logic       cs_n_s = 1'b1;
    logic       frame_valid;
    logic       frame_rw;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_err;
    logic       busy;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    spi_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .sclk_s      (sclk_s),
        .copi_s      (copi_s),
        .cs_n_s      (cs_n_s),
        .frame_valid (frame_valid),
        .frame_rw    (frame_rw),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .busy        (busy),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic       is_err;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: last good frame and frame counter.
    logic       m_rw = 1'b0;
    logic [6:0] m_addr = '0;
    logic [7:0] m_data = '0;
    logic [7:0] m_cnt = '0;
    bit         armed = 1'b0;
    bit         busy_chk = 1'b0;
    logic       cs_at_pos = 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cs_at_pos = cs_n_s;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (frame_valid || frame_err) begin
                chk("exclusive", frame_valid & frame_err, 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: valid=%0b err=%0b expected none",
                             frame_valid, frame_err);
                end else begin
                    e = q.pop_front();
                    chk("kind_err", frame_err, e.is_err);
                    chk("kind_valid", frame_valid, !e.is_err);
                    chk("rw", frame_rw, e.rw);
                    chk("addr", frame_addr, e.addr);
                    chk("data", frame_data, e.data);
                    chk("count", frame_count, e.cnt);
                end
            end
            if (busy_chk) chk("busy", busy, !cs_at_pos);
        end
    end

    task automatic do_reset(input logic cs_level);
        rst = 1'b1;
        cs_n_s = cs_level;
        sclk_s = 1'b0;
        #1;
        chk("rst_valid", frame_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_rw", frame_rw, 0);
        chk("rst_addr", frame_addr, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", frame_count, 0);
        q.delete();
        m_rw = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_cnt = '0;
        armed = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        armed = cs_level;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int h);
        copi_s = b;
        repeat (h) @(posedge clk);
        #1 sclk_s = 1'b1;
        repeat (h) @(posedge clk);
        #1 sclk_s = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] val, input int n, input int h);
        logic [15:0] acc;
        logic        b;
        bit          counted;
        exp_t        e;
        counted = armed;
        repeat (2) @(posedge clk);
        #1 cs_n_s = 1'b0;
        repeat (h) @(posedge clk);
        #1;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            b = val[n-1-i];
            send_bit(b, h);
            if (i < 16) acc = {acc[14:0], b};
        end
        repeat (h) @(posedge clk);
        #1 cs_n_s = 1'b1;
        if (counted) begin
            if (n == 16) begin
                m_rw = acc[15];
                m_addr = acc[14:8];
                m_data = acc[7:0];
                m_cnt = m_cnt + 8'd1;
            end
            e.is_err = (n != 16);
            e.rw = m_rw;
            e.addr = m_addr;
            e.data = m_data;
            e.cnt = m_cnt;
            q.push_back(e);
        end
        armed = 1'b1;
        for (int k = 0; k < 8 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: pending=%0d expected 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        #2;
        do_reset(1'b1);

        send_frame(32'h8480, 16, 4);
        chk("w1_rw", frame_rw, 1);
        chk("w1_addr", frame_addr, 7'h04);
        chk("w1_data", frame_data, 8'h80);
        chk("w1_count", frame_count, 1);

        send_frame(32'h2A5, 10, 4);
        chk("short_addr", frame_addr, 7'h04);
        chk("short_data", frame_data, 8'h80);
        chk("short_count", frame_count, 1);

        send_frame(32'h1ABCD, 17, 3);
        send_frame(32'h0155, 16, 4);
        chk("ovr_rw", frame_rw, 0);
        chk("ovr_addr", frame_addr, 7'h01);
        chk("ovr_data", frame_data, 8'h55);

        do_reset(1'b0);
        send_frame(32'h8480, 16, 4);
        chk("held_low_count", frame_count, 0);
        send_frame(32'h83FF, 16, 4);
        chk("after_hold_addr", frame_addr, 7'h03);
        chk("after_hold_data", frame_data, 8'hFF);

        repeat (2) @(posedge clk);
        #1 cs_n_s = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), 4);
        do_reset(1'b1);
        send_frame(32'h8211, 16, 4);
        chk("mid_rst_addr", frame_addr, 7'h02);
        chk("mid_rst_data", frame_data, 8'h11);
        chk("mid_rst_count", frame_count, 1);

        do_reset(1'b1);
        busy_chk = 1'b1;
        for (int f = 0; f < 256; f++)
            send_frame($urandom_range(0, 16'hFFFF), 16, $urandom_range(2, 4));
        busy_chk = 1'b0;
        chk("wrap_count", frame_count, 0);

        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 2))
                0: n = $urandom_range(1, 15);
                1: n = $urandom_range(17, 20);
                default: n = 16;
            endcase
            send_frame($urandom, n, $urandom_range(2, 4));
        end

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
